bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_prio.sv | 33 +++
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and default widths for the CPU/video bus arbiter
package bus_arbiter_pkg;

   localparam int ADDR_W_DEF        = 16;
   localparam int DATA_W_DEF        = 8;
   localparam int VID_MAX_BURST_DEF = 4;
   localparam int RUN_W             = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_VID = 1'b1
   } owner_t;

endpackage

// File: rtl/bus_arbiter_prio.sv
// rtl/bus_arbiter_prio.sv - combinational grant decision; BUS_ARBITER_FAIRNESS_EN adds the video burst limit
module bus_arbiter_prio
   import bus_arbiter_pkg::*;
#(
   parameter int VID_MAX_BURST = VID_MAX_BURST_DEF
)(
   input  logic             cpu_req,
   input  logic             vid_req,
`ifdef BUS_ARBITER_FAIRNESS_EN
   input  logic [RUN_W-1:0] vid_run,
`endif
   output logic             grant,
   output owner_t           owner
);

   // The run counter is 4 bits wide, so the burst limit must fit in it.
   if (VID_MAX_BURST < 1 || VID_MAX_BURST > 15) begin : g_bad_burst
      $error("VID_MAX_BURST must be in 1..15");
   end

   logic cpu_turn;

   // Video wins ties unless it has used up its burst while the CPU waited.
   always_comb begin
      cpu_turn = 1'b0;
`ifdef BUS_ARBITER_FAIRNESS_EN
      cpu_turn = cpu_req && (vid_run == RUN_W'(VID_MAX_BURST));
`endif
      grant = cpu_req | vid_req;
      owner = (vid_req && !cpu_turn) ? OWN_VID : OWN_CPU;
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - single-port RAM arbiter between 6502 CPU and video fetch; BUS_ARBITER_FAIRNESS_EN enables the burst limit
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int VID_MAX_BURST = VID_MAX_BURST_DEF
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t state;
   state_t state_next;
   owner_t owner;
   owner_t grant_owner;
   logic   grant;
   logic   take;
   logic   is_write;
`ifdef BUS_ARBITER_FAIRNESS_EN
   logic [RUN_W-1:0] vid_run;
`endif

   bus_arbiter_prio #(
      .VID_MAX_BURST (VID_MAX_BURST)
   ) u_prio (
      .cpu_req (cpu_req),
      .vid_req (vid_req),
`ifdef BUS_ARBITER_FAIRNESS_EN
      .vid_run (vid_run),
`endif
      .grant   (grant),
      .owner   (grant_owner)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Requests are only looked at in IDLE; the access phases run unconditionally.
   always_comb begin
      state_next = state;
      take       = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_next = ADDR;
               take       = 1'b1;
            end
         end
         ADDR:    state_next = DATA;
         DATA:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latch the winner and present its access to the RAM; the write strobe lasts only for ADDR.
   always_ff @(posedge clock) begin
      if (reset) begin
         owner     <= OWN_CPU;
         is_write  <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else if (take) begin
         owner <= grant_owner;
         if (grant_owner == OWN_CPU) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_wdata;
            is_write  <= cpu_we;
         end else begin
            mem_addr <= vid_addr;
            mem_we   <= 1'b0;
            is_write <= 1'b0;
         end
      end else begin
         mem_we <= 1'b0;
      end
   end

   // RAM data is valid in DATA; route it to the owner, leaving cpu_rdata alone on writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         cpu_rdata <= '0;
         vid_rdata <= '0;
      end else if (state == DATA) begin
         if (owner == OWN_VID) begin
            vid_rdata <= mem_rdata;
         end else if (!is_write) begin
            cpu_rdata <= mem_rdata;
         end
      end
   end

`ifdef BUS_ARBITER_FAIRNESS_EN
   // Count video grants taken while the CPU was kept waiting.
   always_ff @(posedge clock) begin
      if (reset) begin
         vid_run <= '0;
      end else if (take) begin
         if (grant_owner == OWN_CPU) begin
            vid_run <= '0;
         end else if (cpu_req) begin
            vid_run <= vid_run + RUN_W'(1);
         end
      end
   end
`endif

   assign cpu_ack = (state == DONE) && (owner == OWN_CPU);
   assign vid_ack = (state == DONE) && (owner == OWN_VID);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int VMB = 4;
`ifdef BUS_ARBITER_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_ack;
   logic [DW-1:0] vid_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   bus_arbiter #(
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .VID_MAX_BURST (VMB)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_ack   (vid_ack),
      .vid_rdata (vid_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Synchronous single-port RAM driven by the DUT.
   logic [DW-1:0] ram    [0:65535];
   logic [DW-1:0] shadow [0:65535];

   always @(posedge clock) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one access occupies the grant edge plus three cycles,
   // the answer comes from a shadow memory updated when each write is granted.
   int            since_grant = 0;
   int            streak      = 0;
   bit            m_cpu       = 1'b0;
   bit            m_we        = 1'b0;
   bit            m_to_cpu    = 1'b0;
   logic [DW-1:0] m_data      = '0;
   logic [AW-1:0] e_addr      = '0;
   logic          e_we        = 1'b0;
   logic [DW-1:0] e_wdata     = '0;
   logic [DW-1:0] e_crd       = '0;
   logic [DW-1:0] e_vrd       = '0;

   always @(posedge clock) begin
      if (reset) begin
         since_grant = 0;
         streak      = 0;
         e_addr      = '0;
         e_we        = 1'b0;
         e_wdata     = '0;
         e_crd       = '0;
         e_vrd       = '0;
      end else if (since_grant == 0) begin
         if (cpu_req || vid_req) begin
            m_to_cpu = !vid_req || (FAIR && cpu_req && streak == VMB);
            if (m_to_cpu) begin
               m_cpu   = 1'b1;
               streak  = 0;
               e_addr  = cpu_addr;
               e_we    = cpu_we;
               e_wdata = cpu_wdata;
               m_we    = cpu_we;
               if (cpu_we) shadow[cpu_addr] = cpu_wdata;
               else        m_data = shadow[cpu_addr];
            end else begin
               m_cpu  = 1'b0;
               m_we   = 1'b0;
               if (cpu_req) streak++;
               e_addr = vid_addr;
               e_we   = 1'b0;
               m_data = shadow[vid_addr];
            end
            since_grant = 1;
         end
      end else begin
         since_grant++;
         e_we = 1'b0;
         if (since_grant == 3) begin
            if (m_cpu && !m_we) e_crd = m_data;
            if (!m_cpu)         e_vrd = m_data;
         end
         if (since_grant == 4) since_grant = 0;
      end
      #1;
      check("cpu_ack",   cpu_ack,   (since_grant == 3) && m_cpu);
      check("vid_ack",   vid_ack,   (since_grant == 3) && !m_cpu);
      check("mem_we",    mem_we,    e_we);
      check("mem_addr",  mem_addr,  e_addr);
      check("cpu_rdata", cpu_rdata, e_crd);
      check("vid_rdata", vid_rdata, e_vrd);
      if (e_we || reset) check("mem_wdata", mem_wdata, e_wdata);
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic new_cpu();
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 7));
      cpu_wdata = 8'($urandom);
   endtask

   task automatic new_vid();
      vid_req  = 1'b1;
      vid_addr = 16'($urandom_range(0, 7));
   endtask

   bit order[$];
   int n_cpu;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i]    = 8'($urandom);
         shadow[i] = ram[i];
      end
      ram[16'h1234]    = 8'hA5;
      shadow[16'h1234] = 8'hA5;

      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst_cpu_ack",   cpu_ack,   0);
      check("rst_vid_ack",   vid_ack,   0);
      check("rst_mem_we",    mem_we,    0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_vid_rdata", vid_rdata, 0);

      // CPU read of 0x1234, held into DONE
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      step();
      check("rd_mem_addr", mem_addr, 16'h1234);
      step();
      check("rd_early_ack", cpu_ack, 0);
      step();
      check("rd_cpu_ack",   cpu_ack,   1);
      check("rd_cpu_rdata", cpu_rdata, 8'hA5);
      check("rd_vid_ack",   vid_ack,   0);
      step();
      cpu_req = 1'b0;
      check("rd_ack_once", cpu_ack, 0);
      step();
      check("rd_no_reaccess", cpu_ack, 0);

      // CPU write 0x0200 <= 0x3C
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h3C;
      step();
      check("wr_mem_we",    mem_we,    1);
      check("wr_mem_addr",  mem_addr,  16'h0200);
      check("wr_mem_wdata", mem_wdata, 8'h3C);
      step();
      check("wr_we_drop", mem_we,  0);
      check("wr_no_ack",  cpu_ack, 0);
      step();
      check("wr_cpu_ack",   cpu_ack,   1);
      check("wr_rdata_kept", cpu_rdata, 8'hA5);
      cpu_req = 1'b0; cpu_we = 1'b0;
      step();

      // Simultaneous requests with a fresh counter
      reset = 1'b1;
      step();
      reset = 1'b0;
      vid_addr = 16'h0200; vid_req = 1'b1;
      cpu_addr = 16'h1234; cpu_req = 1'b1; cpu_we = 1'b0;
      order.delete();
      for (int c = 0; c < 40 && order.size() < 2; c++) begin
         step();
         if (vid_ack) begin
            order.push_back(1'b1);
            check("both_vid_rdata", vid_rdata, 8'h3C);
            vid_req = 1'b0;
         end
         if (cpu_ack) begin
            order.push_back(1'b0);
            check("both_cpu_rdata", cpu_rdata, 8'hA5);
            cpu_req = 1'b0;
         end
      end
      check("both_count", order.size(), 2);
      if (order.size() == 2) begin
         check("both_first_vid",  order[0], 1);
         check("both_second_cpu", order[1], 0);
      end
      step();

      // Both requesters continuously asking
      reset = 1'b1;
      step();
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
      vid_req = 1'b1; vid_addr = 16'h0004;
      order.delete();
      for (int c = 0; c < 100 && order.size() < 10; c++) begin
         step();
         if (vid_ack) order.push_back(1'b1);
         if (cpu_ack) order.push_back(1'b0);
      end
      check("burst_count", order.size(), 10);
      n_cpu = 0;
      for (int i = 0; i < order.size(); i++) begin
         check("burst_order", order[i], FAIR ? ((i % (VMB + 1)) != VMB) : 1'b1);
         if (!order[i]) n_cpu++;
      end
      check("burst_cpu_grants", n_cpu, FAIR ? 2 : 0);
      cpu_req = 1'b0; vid_req = 1'b0;
      for (int c = 0; c < 5; c++) step();

      // Reset in DATA of a video read aborts it
      vid_req = 1'b1; vid_addr = 16'h0005;
      for (int c = 0; c < 8 && !(vid_ack == 1'b0 && mem_addr == 16'h0005 && mem_we == 1'b0); c++) step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      vid_req = 1'b0;
      check("abort_vid_ack",   vid_ack,   0);
      check("abort_mem_we",    mem_we,    0);
      check("abort_mem_addr",  mem_addr,  0);
      check("abort_mem_wdata", mem_wdata, 0);
      check("abort_cpu_rdata", cpu_rdata, 0);
      check("abort_vid_rdata", vid_rdata, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         check("abort_no_late_ack", vid_ack, 0);
      end

      // Random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if (cpu_req) begin
            if (cpu_ack) begin
               if ($urandom_range(0, 2) == 0) new_cpu();
               else cpu_req = 1'b0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            new_cpu();
         end
         if (vid_req) begin
            if (vid_ack) begin
               if ($urandom_range(0, 1) == 0) new_vid();
               else vid_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            new_vid();
         end
         step();
      end
      reset = 1'b0;
      cpu_req = 1'b0;
      vid_req = 1'b0;
      for (int c = 0; c < 5; c++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
